// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Request/grant arbiter sharing one memory port between fetch and
//            data. Optional macro MEM_ARB_STARVE_GUARD_EN adds fetch anti-starvation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_func,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_func,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int         c_LAT_W     = 2;
  localparam logic [2:0] c_FUNC_WORD = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_owner_d;
  logic                 r_we;
  logic [c_LAT_W-1:0]   r_lat_cnt;
  logic [DATA_W-1:0]    r_if_rdata;
  logic [DATA_W-1:0]    r_d_rdata;
  logic [2:0]           r_func;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic                 w_arb;
  logic                 w_force_if;
  logic                 w_d_win;
  logic                 w_if_win;

  // Arbitration only happens when the port is free; reset suppresses grants.
  assign w_arb    = (r_state != S_BUSY) && !rst;
  assign w_d_win  = d_req && !w_force_if;
  assign w_if_win = if_req && !w_d_win;
  assign if_gnt   = w_arb && w_if_win;
  assign d_gnt    = w_arb && w_d_win;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int c_STARVE_W = $clog2(STARVE_MAX + 1);
  logic [c_STARVE_W-1:0] r_starve_cnt;

  assign w_force_if = if_req && (r_starve_cnt == c_STARVE_W'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (if_gnt) begin
      r_starve_cnt <= '0;
    end else if (d_gnt && if_req && (r_starve_cnt != c_STARVE_W'(STARVE_MAX))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  logic w_unused_starve;
  assign w_force_if      = 1'b0;
  assign w_unused_starve = (STARVE_MAX != 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_RESP: w_state_nxt = (if_gnt || d_gnt) ? S_BUSY : S_IDLE;
      S_BUSY:         if (r_lat_cnt == '0) w_state_nxt = S_RESP;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_d  <= 1'b0;
      r_we       <= 1'b0;
      r_func     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_lat_cnt  <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if (d_gnt) begin
      r_owner_d <= 1'b1;
      r_we      <= d_we;
      r_func    <= d_func;
      r_addr    <= d_addr;
      r_wdata   <= d_wdata;
      r_lat_cnt <= c_LAT_W'(MEM_LAT - 1);
    end else if (if_gnt) begin
      // Fetch leaves the store-data register untouched.
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_func    <= c_FUNC_WORD;
      r_addr    <= if_addr;
      r_lat_cnt <= c_LAT_W'(MEM_LAT - 1);
    end else if (r_state == S_BUSY) begin
      if (r_lat_cnt == '0) begin
        if (r_owner_d) r_d_rdata  <= r_we ? '0 : mem_rdata;
        else           r_if_rdata <= mem_rdata;
      end else begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end
    end
  end

  assign mem_en    = (r_state == S_BUSY);
  assign mem_read  = mem_en && !r_we;
  assign mem_write = mem_en && r_we;
  assign mem_func  = r_func;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rvalid = (r_state == S_RESP) && !r_owner_d;
  assign d_rvalid  = (r_state == S_RESP) && r_owner_d;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter (MEM_LAT 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_func;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem_rdata3;

  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_read, mem_write;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_func;

  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_read3, mem_write3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;
  logic [2:0]  mem_func3;

  logic [31:0] mem [0:255];
  int          wr_cnt;
  int          n_checks;
  int          n_errors;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_func(d_func), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write), .mem_func(mem_func),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3),
    .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req), .d_we(d_we), .d_func(d_func), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_read(mem_read3), .mem_write(mem_write3), .mem_func(mem_func3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory model behind the MEM_LAT=1 instance.
  assign mem_rdata  = mem[mem_addr[9:2]];
  assign mem_rdata3 = 32'h1234_5678;

  always @(posedge clk) begin
    if (mem_en && mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  int dg;
  int first_if;
  int drv3;

  initial begin
    n_checks = 0;
    n_errors = 0;
    wr_cnt   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'h00A0_0093;
    mem[8'h40] = 32'h1111_2222;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_func = '0; d_addr = '0; d_wdata = '0;
    tick(); tick();

    // Reset state
    rst = 1'b0;
    settle();
    check("rst_mem_en",   {31'b0, mem_en}, 32'd0);
    check("rst_rvalid",   {30'b0, if_rvalid, d_rvalid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    tick();

    // Single fetch, MEM_LAT=1
    if_req = 1'b1; if_addr = 32'h40;
    settle();
    check("fetch_gnt", {30'b0, if_gnt, d_gnt}, 32'd2);
    tick();
    if_req = 1'b0;
    settle();
    check("fetch_strobes", {29'b0, mem_en, mem_read, mem_write}, 32'd6);
    check("fetch_addr",    mem_addr, 32'h40);
    check("fetch_func",    {29'b0, mem_func}, 32'd2);
    tick();
    settle();
    check("fetch_rvalid", {30'b0, if_rvalid, mem_en}, 32'd2);
    check("fetch_rdata",  if_rdata, 32'h00A0_0093);
    tick();

    // Simultaneous requests: data first, fetch granted in RESP
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_func = 3'b100; d_addr = 32'h100;
    settle();
    check("both_gnt", {30'b0, if_gnt, d_gnt}, 32'd1);
    tick();
    d_req = 1'b0;
    settle();
    check("both_busy_nogrant", {31'b0, if_gnt}, 32'd0);
    check("load_addr",         mem_addr, 32'h100);
    check("load_func",         {29'b0, mem_func}, 32'd4);
    tick();
    settle();
    check("load_rvalid_ifgnt", {30'b0, d_rvalid, if_gnt}, 32'd3);
    check("load_rdata",        d_rdata, 32'h1111_2222);
    tick();
    if_req = 1'b0;
    settle();
    check("fetch2_func", {29'b0, mem_func}, 32'd2);
    check("fetch2_addr", mem_addr, 32'h40);
    tick();
    settle();
    check("fetch2_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd2);
    tick();

    // Store then load-back
    wr_cnt = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_func = 3'b010; d_wdata = 32'hDEAD_BEEF;
    settle();
    check("store_gnt", {31'b0, d_gnt}, 32'd1);
    tick();
    d_req = 1'b0;
    settle();
    check("store_strobes", {29'b0, mem_en, mem_read, mem_write}, 32'd5);
    check("store_wdata",   mem_wdata, 32'hDEAD_BEEF);
    tick();
    d_req = 1'b1; d_we = 1'b0;
    settle();
    check("store_ack",       {29'b0, d_rvalid, mem_write, d_gnt}, 32'd5);
    check("store_ack_rdata", d_rdata, 32'd0);
    tick();
    d_req = 1'b0;
    settle();
    check("reload_read", {30'b0, mem_read, mem_write}, 32'd2);
    tick();
    settle();
    check("reload_rdata",  d_rdata, 32'hDEAD_BEEF);
    check("reload_rvalid", {31'b0, d_rvalid}, 32'd1);
    check("store_wr_cnt",  wr_cnt, 32'd1);
    tick();

    // Reset mid-operation (MEM_LAT=1 instance)
    d_req = 1'b1; d_addr = 32'h100;
    settle();
    tick();
    d_req = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    settle();
    check("midrst_outputs",
          {25'b0, mem_en, mem_read, mem_write, if_gnt, d_gnt, if_rvalid, d_rvalid}, 32'd0);
    tick();

    // Starvation
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; if_req = 1'b1; if_addr = 32'h40;
    dg = 0; first_if = -1;
    for (int c = 0; c < 16; c++) begin
      settle();
      if (if_gnt && first_if < 0) first_if = dg;
      if (d_gnt) dg++;
      tick();
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    check("starve_if_after_dgnts", first_if, 32'd4);
`else
    check("starve_no_if_gnt", first_if, 32'hFFFF_FFFF);
    check("starve_dgnt_count", dg, 32'd8);
`endif
    d_req = 1'b0; if_req = 1'b0;
    tick(); tick(); tick();

    // Reset in second BUSY cycle, MEM_LAT=3 instance
    drv3 = 0;
    d_req = 1'b1; d_addr = 32'h100;
    settle();
    check("lat3_dgnt", {31'b0, d_gnt3}, 32'd1);
    tick();
    d_req = 1'b0;
    settle();
    check("lat3_busy1", {31'b0, mem_en3}, 32'd1);
    tick();
    rst = 1'b1;
    settle();
    if (d_rvalid3) drv3++;
    tick();
    settle();
    if (d_rvalid3) drv3++;
    check("lat3_rst_mem_en", {31'b0, mem_en3}, 32'd0);
    tick();
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h40;
    settle();
    if (d_rvalid3) drv3++;
    check("lat3_post_rst_if_gnt", {31'b0, if_gnt3}, 32'd1);
    tick();
    if_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      if (d_rvalid3) drv3++;
      check("lat3_fetch_busy", {30'b0, mem_en3, if_rvalid3}, 32'd2);
      tick();
    end
    settle();
    if (d_rvalid3) drv3++;
    check("lat3_fetch_rvalid", {30'b0, if_rvalid3, mem_en3}, 32'd2);
    check("lat3_fetch_rdata",  if_rdata3, 32'h1234_5678);
    tick();
    for (int k = 0; k < 4; k++) begin
      settle();
      if (d_rvalid3) drv3++;
      tick();
    end
    check("lat3_no_d_rvalid", drv3, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
